// File: rtl/adc_frame_packer.sv
// rtl/adc_frame_packer.sv - captures ADC frames, serialises selected channels into a FIFO, drains as an AXI-Stream packet
// Optional test-pattern source: ADC_FRAME_PACKER_TEST_PATTERN_EN
module adc_frame_packer #(
  parameter int NUM_CH     = 4,
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 512,
  parameter int LEN_W      = 32
) (
  input  logic                     adc_clk,
  input  logic                     adc_rst_n,
  input  logic                     in_valid,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic                     sample_start,
  input  logic [LEN_W-1:0]         sample_len,
  input  logic [NUM_CH-1:0]        ch_sel,
  output logic                     sample_en,
  output logic                     st_clr,
  output logic                     busy,
  output logic                     overflow,
  output logic [DATA_W-1:0]        m_axis_tdata,
  output logic [DATA_W/8-1:0]      m_axis_tkeep,
  output logic                     m_axis_tvalid,
  output logic                     m_axis_tlast,
  input  logic                     m_axis_tready
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int WW = LEN_W + 5;

  typedef enum logic [1:0] {IDLE, SAMP, DRAIN} state_t;

  function automatic logic [4:0] popcnt(input logic [NUM_CH-1:0] m);
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < NUM_CH; i++) c = c + 5'(m[i]);
    return c;
  endfunction

  state_t                   state_q, state_d;
  logic                     start_d0, start_d1;
  logic [LEN_W-1:0]         len_q, frame_cnt;
  logic [NUM_CH-1:0]        sel_q, rem_q;
  logic [4:0]               nsel_q;
  logic [WW-1:0]            last_word_q, wcnt_q;
  logic [NUM_CH*DATA_W-1:0] hold_q, frame_in;
  logic                     overflow_q, st_clr_q;
  logic [AW:0]              wptr, rptr, fifo_cnt, free;
  logic [DATA_W:0]          mem [FIFO_DEPTH];
  logic [DATA_W-1:0]        out_data, wr_data;
  logic                     out_last, out_valid;
  logic [CW-1:0]            ser_idx;
  logic                     rise, start_ok, in_take, accept, drop, ser_busy, wr_last;
  logic                     fifo_empty, out_ready, rd_en, bypass, fifo_wr;

`ifdef ADC_FRAME_PACKER_TEST_PATTERN_EN
  always_comb begin
    frame_in = '0;
    for (int k = 0; k < NUM_CH; k++)
      frame_in[k*DATA_W +: DATA_W] = {4'(k), frame_cnt[DATA_W-5:0]};
  end
`else
  assign frame_in = in_data;
`endif

  assign rise       = start_d0 & ~start_d1;
  assign start_ok   = (state_q == IDLE) & rise & (|sample_len) & (|ch_sel);
  assign fifo_cnt   = wptr - rptr;
  assign fifo_empty = (wptr == rptr);
  assign free       = (AW+1)'(FIFO_DEPTH) - fifo_cnt;
  assign ser_busy   = |rem_q;
  // A frame is only taken when it fits whole, so the FIFO can never be written while full.
  assign in_take    = (state_q == SAMP) & in_valid & (frame_cnt < len_q);
  assign accept     = in_take & ~ser_busy & (32'(free) >= 32'(nsel_q));
  assign drop       = in_take & ~accept;

  always_comb begin
    ser_idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (rem_q[i]) ser_idx = CW'(i);
  end

  assign wr_data   = hold_q[ser_idx*DATA_W +: DATA_W];
  assign wr_last   = (wcnt_q == last_word_q);
  assign out_ready = ~out_valid | m_axis_tready;
  assign rd_en     = ~fifo_empty & out_ready;
  // An empty FIFO hands the serialiser word straight to the output register.
  assign bypass    = fifo_empty & out_ready & ser_busy;
  assign fifo_wr   = ser_busy & ~bypass;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_ok) state_d = SAMP;
      SAMP:    if (ser_busy && wr_last) state_d = DRAIN;
      DRAIN:   if (out_valid && m_axis_tready && out_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge adc_clk) begin
    if (!adc_rst_n) begin
      state_q     <= IDLE;
      start_d0    <= 1'b0;
      start_d1    <= 1'b0;
      len_q       <= '0;
      sel_q       <= '0;
      nsel_q      <= '0;
      last_word_q <= '0;
      frame_cnt   <= '0;
      wcnt_q      <= '0;
      hold_q      <= '0;
      rem_q       <= '0;
      overflow_q  <= 1'b0;
      st_clr_q    <= 1'b0;
      wptr        <= '0;
      rptr        <= '0;
      out_data    <= '0;
      out_last    <= 1'b0;
      out_valid   <= 1'b0;
    end else begin
      start_d0 <= sample_start;
      start_d1 <= start_d0;
      state_q  <= state_d;
      st_clr_q <= start_ok;
      if (start_ok) begin
        len_q       <= sample_len;
        sel_q       <= ch_sel;
        nsel_q      <= popcnt(ch_sel);
        last_word_q <= WW'(sample_len) * WW'(popcnt(ch_sel)) - WW'(1);
        frame_cnt   <= '0;
        wcnt_q      <= '0;
        overflow_q  <= 1'b0;
      end
      if (drop) overflow_q <= 1'b1;
      if (accept) begin
        hold_q    <= frame_in;
        rem_q     <= sel_q;
        frame_cnt <= frame_cnt + LEN_W'(1);
      end else if (ser_busy) begin
        rem_q <= rem_q & (rem_q - NUM_CH'(1));
      end
      if (ser_busy) wcnt_q <= wcnt_q + WW'(1);
      if (fifo_wr) wptr <= wptr + (AW+1)'(1);
      if (rd_en) begin
        rptr      <= rptr + (AW+1)'(1);
        out_data  <= mem[rptr[AW-1:0]][DATA_W-1:0];
        out_last  <= mem[rptr[AW-1:0]][DATA_W];
        out_valid <= 1'b1;
      end else if (bypass) begin
        out_data  <= wr_data;
        out_last  <= wr_last;
        out_valid <= 1'b1;
      end else if (m_axis_tready) begin
        out_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge adc_clk) begin
    if (fifo_wr) mem[wptr[AW-1:0]] <= {wr_last, wr_data};
  end

  assign sample_en     = (state_q == SAMP);
  assign st_clr        = st_clr_q;
  assign busy          = (state_q != IDLE);
  assign overflow      = overflow_q;
  assign m_axis_tdata  = out_data;
  assign m_axis_tkeep  = '1;
  assign m_axis_tvalid = out_valid;
  assign m_axis_tlast  = out_last;

endmodule

// File: tb/tb_adc_frame_packer.sv
// tb/tb_adc_frame_packer.sv - scoreboard bench for adc_frame_packer (4 ch, 16-bit, 16-word FIFO)
module tb_adc_frame_packer;

  logic        clk = 1'b0;
  logic        adc_rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [63:0] in_data = '0;
  logic        sample_start = 1'b0;
  logic [31:0] sample_len = '0;
  logic [3:0]  ch_sel = '0;
  logic        sample_en, st_clr, busy, overflow;
  logic [15:0] m_axis_tdata;
  logic [1:0]  m_axis_tkeep;
  logic        m_axis_tvalid, m_axis_tlast;
  logic        m_axis_tready = 1'b1;

  adc_frame_packer #(.NUM_CH(4), .DATA_W(16), .FIFO_DEPTH(16), .LEN_W(32)) dut (
    .adc_clk(clk), .adc_rst_n(adc_rst_n), .in_valid(in_valid), .in_data(in_data),
    .sample_start(sample_start), .sample_len(sample_len), .ch_sel(ch_sel),
    .sample_en(sample_en), .st_clr(st_clr), .busy(busy), .overflow(overflow),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0, n_err = 0;
  int          hs_cnt = 0, st_cnt = 0;
  logic [16:0] exp_q[$];
  logic [3:0]  cur_sel;
  int          exp_total, exp_widx, fidx;
  logic        stall_prev = 1'b0;
  logic [16:0] prev_out;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every handshake, checks stall stability.
  always @(negedge clk) begin
    if (!adc_rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (st_clr) st_cnt++;
      if (stall_prev) chk("stall_stable", {47'd0, m_axis_tlast, m_axis_tdata}, {47'd0, prev_out});
      if (m_axis_tvalid && m_axis_tready) begin
        hs_cnt++;
        if (exp_q.size() == 0) chk("unexpected_word", {47'd0, m_axis_tlast, m_axis_tdata}, 64'h1_0000_0000);
        else chk("stream_word", {47'd0, m_axis_tlast, m_axis_tdata}, {47'd0, exp_q.pop_front()});
      end
      stall_prev = m_axis_tvalid & ~m_axis_tready;
      prev_out   = {m_axis_tlast, m_axis_tdata};
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [15:0] exp_word(input int k, input int fi, input logic [63:0] d);
`ifdef ADC_FRAME_PACKER_TEST_PATTERN_EN
    return {4'(k), 12'(fi)};
`else
    return d[k*16 +: 16];
`endif
  endfunction

  task automatic push_frame(input logic [63:0] d);
    for (int k = 0; k < 4; k++)
      if (cur_sel[k]) begin
        exp_q.push_back({exp_widx == exp_total - 1, exp_word(k, fidx, d)});
        exp_widx++;
      end
    fidx++;
  endtask

  task automatic send_frame(input logic [63:0] d, input bit accepted, input int gap);
    if (accepted) push_frame(d);
    in_data  = d;
    in_valid = 1'b1;
    cyc(1);
    in_valid = 1'b0;
    cyc(gap);
  endtask

  task automatic start_capture(input int len, input logic [3:0] sel);
    sample_start = 1'b0;
    sample_len   = len;
    ch_sel       = sel;
    cyc(2);
    sample_start = 1'b1;
    cur_sel      = sel;
    exp_total    = len * $countones(sel);
    exp_widx     = 0;
    fidx         = 0;
    cyc(3);
  endtask

  task automatic wait_done(input string name, input int budget);
    int i;
    i = 0;
    while ((busy || exp_q.size() != 0) && i < budget) begin
      cyc(1);
      i++;
    end
    chk({name, "_drained"}, 64'(exp_q.size()), 64'd0);
    chk({name, "_busy_low"}, {63'd0, busy}, 64'd0);
  endtask

  function automatic logic [63:0] fr(input logic [15:0] base);
    return {base + 16'd3, base + 16'd2, base + 16'd1, base};
  endfunction

  int st0;

  initial begin
    cyc(3);
    chk("rst_tvalid", {63'd0, m_axis_tvalid}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_overflow", {63'd0, overflow}, 64'd0);
    chk("rst_sample_en", {63'd0, sample_en}, 64'd0);
    chk("rst_tkeep", {62'd0, m_axis_tkeep}, 64'd3);
    adc_rst_n = 1'b1;
    cyc(2);

    // Basic capture with first-word latency check.
    st0 = st_cnt;
    start_capture(3, 4'b1111);
    chk("basic_sample_en", {63'd0, sample_en}, 64'd1);
    push_frame(fr(16'hA000));
    in_data = fr(16'hA000);
    in_valid = 1'b1;
    cyc(1);
    in_valid = 1'b0;
    chk("lat_t1_tvalid", {63'd0, m_axis_tvalid}, 64'd0);
    cyc(1);
    chk("lat_t2_tvalid", {63'd0, m_axis_tvalid}, 64'd1);
    cyc(6);
    send_frame(fr(16'hB000), 1, 7);
    send_frame(fr(16'hC000), 1, 7);
    wait_done("basic", 100);
    chk("basic_st_clr_once", 64'(st_cnt - st0), 64'd1);
    chk("basic_overflow", {63'd0, overflow}, 64'd0);

    // Sparse mask.
    start_capture(2, 4'b1010);
    send_frame(64'h3333_BEEF_1111_DEAD, 1, 7);
    send_frame(64'h3333_BEEF_1111_DEAD, 1, 7);
    wait_done("sparse", 100);

    // Held-high start after completion must not retrigger.
    st0 = st_cnt;
    cyc(10);
    chk("held_no_restart_busy", {63'd0, busy}, 64'd0);
    chk("held_no_restart_st", 64'(st_cnt - st0), 64'd0);

    // Illegal starts.
    start_capture(0, 4'b1111);
    chk("illegal_len_busy", {63'd0, busy}, 64'd0);
    start_capture(2, 4'b0000);
    send_frame(fr(16'h7000), 0, 4);
    chk("illegal_sel_busy", {63'd0, busy}, 64'd0);
    chk("illegal_st_clr", 64'(st_cnt - st0), 64'd0);

    // Back-pressure: four frames fill 1 + 15 words, next three are dropped whole.
    m_axis_tready = 1'b0;
    start_capture(6, 4'b1111);
    send_frame(fr(16'h1000), 1, 5);
    send_frame(fr(16'h1100), 1, 5);
    send_frame(fr(16'h1200), 1, 5);
    send_frame(fr(16'h1300), 1, 5);
    send_frame(fr(16'h1400), 0, 5);
    send_frame(fr(16'h1500), 0, 5);
    send_frame(fr(16'h1600), 0, 5);
    chk("bp_overflow", {63'd0, overflow}, 64'd1);
    m_axis_tready = 1'b1;
    cyc(10);
    send_frame(fr(16'h1700), 1, 5);
    send_frame(fr(16'h1800), 1, 5);
    wait_done("backpressure", 200);
    chk("bp_overflow_sticky", {63'd0, overflow}, 64'd1);

    // Reset mid-capture.
    start_capture(3, 4'b1111);
    chk("rstmid_overflow_cleared", {63'd0, overflow}, 64'd0);
    st0 = hs_cnt;
    send_frame(fr(16'h5000), 1, 7);
    send_frame(fr(16'h5100), 1, 0);
    for (int i = 0; i < 50 && hs_cnt - st0 < 5; i++) cyc(1);
    chk("rstmid_reached5", {63'd0, (hs_cnt - st0) >= 5}, 64'd1);
    adc_rst_n    = 1'b0;
    sample_start = 1'b0;
    cyc(1);
    adc_rst_n = 1'b1;
    exp_q.delete();
    chk("rstmid_tvalid", {63'd0, m_axis_tvalid}, 64'd0);
    chk("rstmid_busy", {63'd0, busy}, 64'd0);
    cyc(5);
    chk("rstmid_quiet", {63'd0, m_axis_tvalid}, 64'd0);
    start_capture(3, 4'b1111);
    send_frame(fr(16'h6000), 1, 7);
    send_frame(fr(16'h6100), 1, 7);
    send_frame(fr(16'h6200), 1, 7);
    wait_done("rstmid_new", 100);

    // Alternate mask; in the pattern build this yields 0000,2000,0001,2001.
    start_capture(2, 4'b0101);
    send_frame(fr(16'h9000), 1, 7);
    send_frame(fr(16'h9100), 1, 7);
    wait_done("pattern", 100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
